// File: rtl/dcache_refill_buffer_if.sv
`default_nettype none
// ============================================================================
// Module      : dcache_refill_buffer_if
// Description : Bundles the signals around the data-cache refill buffer:
//               - the miss request, with the store captured alongside it
//               - the AXI read address and read data channels
//               - the line write port into the data RAM
//               - the done/err status pulses
// Revision    : 1.0 - initial release
// ============================================================================
interface dcache_refill_buffer_if #(
    parameter int INDEX_W    = 7,
    parameter int LINE_WORDS = 8
);
    // Miss request plus the store that triggered it
    logic                       req_valid;
    logic                       req_ready;
    logic [31:0]                req_addr;
    logic                       st_valid;
    logic [2:0]                 st_word;
    logic [3:0]                 st_wstrb;
    logic [31:0]                st_data;

    // AXI read address channel
    logic                       arvalid;
    logic                       arready;
    logic [31:0]                araddr;
    logic [7:0]                 arlen;
    logic [2:0]                 arsize;
    logic [1:0]                 arburst;

    // AXI read data channel
    logic                       rvalid;
    logic                       rready;
    logic [31:0]                rdata;
    logic                       rlast;

    // Data RAM line write
    logic [LINE_WORDS*4-1:0]    ram_wen;
    logic [INDEX_W-1:0]         ram_windex;
    logic [LINE_WORDS*32-1:0]   ram_wdata;

    // Status
    logic                       done;
    logic                       err;

    // Cache pipeline / memory side: raises misses, answers the AXI read
    modport master (
        output req_valid, req_addr, st_valid, st_word, st_wstrb, st_data,
        output arready, rvalid, rdata, rlast,
        input  req_ready, arvalid, araddr, arlen, arsize, arburst,
        input  rready, ram_wen, ram_windex, ram_wdata, done, err
    );

    // Refill buffer side
    modport slave (
        input  req_valid, req_addr, st_valid, st_word, st_wstrb, st_data,
        input  arready, rvalid, rdata, rlast,
        output req_ready, arvalid, araddr, arlen, arsize, arburst,
        output rready, ram_wen, ram_windex, ram_wdata, done, err
    );
endinterface
`default_nettype wire

// File: rtl/dcache_refill_buffer.sv
`default_nettype none
// ============================================================================
// Module      : dcache_refill_buffer
// Description : Accepts a cache miss and issues one 8-beat INCR AXI read.
//               - Assembles the returned beats into a 256-bit line.
//               - Writes the line into the data RAM in a single cycle.
//               - Pulses done, and pulses err when rlast framing was wrong.
//               Optional feature macro REFILL_STORE_MERGE_EN: overlays the
//               store captured with the miss onto the refilled line.
// Revision    : 1.0 - initial release
// ============================================================================
module dcache_refill_buffer #(
    parameter int LINE_WORDS = 8,
    parameter int INDEX_W    = 7
) (
    input wire                      clk,
    input wire                      resetn,
    dcache_refill_buffer_if.slave   bus
);

    localparam int          c_line_bits = LINE_WORDS * 32;
    localparam logic [2:0]  c_last_beat = 3'(LINE_WORDS - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ADDR  = 2'd1,
        ST_RECV  = 2'd2,
        ST_WRITE = 2'd3
    } state_t;

    state_t                     state_q, state_d;
    logic [26:0]                line_addr_q, line_addr_d;
    logic [2:0]                 beat_q, beat_d;
    logic                       err_q, err_d;
    logic [c_line_bits-1:0]     line_q, line_d;

    logic                       w_accept;
    logic [c_line_bits-1:0]     w_line_merged;
    logic                       w_unused;

    assign w_accept = (state_q == ST_IDLE) && bus.req_valid;

    // Burst shape never changes; the address is only looked at while arvalid is high
    assign bus.araddr     = {line_addr_q, 5'b0};
    assign bus.arlen      = 8'(LINE_WORDS - 1);
    assign bus.arsize     = 3'd2;
    assign bus.arburst    = 2'b01;
    assign bus.ram_windex = line_addr_q[INDEX_W-1:0];
    assign bus.ram_wdata  = w_line_merged;

    // State, latched miss address, beat counter, framing flag and line buffer
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= ST_IDLE;
            line_addr_q <= '0;
            beat_q      <= '0;
            err_q       <= 1'b0;
            line_q      <= '0;
        end else begin
            state_q     <= state_d;
            line_addr_q <= line_addr_d;
            beat_q      <= beat_d;
            err_q       <= err_d;
            line_q      <= line_d;
        end
    end

    // Next-state and outputs: request -> address -> 8 beats -> one-cycle RAM write
    always_comb begin
        state_d       = state_q;
        line_addr_d   = line_addr_q;
        beat_d        = beat_q;
        err_d         = err_q;
        line_d        = line_q;
        bus.req_ready = 1'b0;
        bus.arvalid   = 1'b0;
        bus.rready    = 1'b0;
        bus.ram_wen   = '0;
        bus.done      = 1'b0;
        bus.err       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                bus.req_ready = 1'b1;
                if (w_accept) begin
                    line_addr_d = bus.req_addr[31:5];
                    beat_d      = '0;
                    err_d       = 1'b0;
                    state_d     = ST_ADDR;
                end
            end
            ST_ADDR: begin
                bus.arvalid = 1'b1;
                if (bus.arready) begin
                    state_d = ST_RECV;
                end
            end
            ST_RECV: begin
                bus.rready = 1'b1;
                if (bus.rvalid) begin
                    line_d[{beat_q, 5'b0} +: 32] = bus.rdata;
                    // rlast must be high on the final beat and only there
                    if (bus.rlast != (beat_q == c_last_beat)) begin
                        err_d = 1'b1;
                    end
                    beat_d = beat_q + 3'd1;
                    if (beat_q == c_last_beat) begin
                        state_d = ST_WRITE;
                    end
                end
            end
            ST_WRITE: begin
                bus.ram_wen = '1;
                bus.done    = 1'b1;
                bus.err     = err_q;
                state_d     = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

`ifdef REFILL_STORE_MERGE_EN
    logic           st_valid_q, st_valid_d;
    logic [2:0]     st_word_q, st_word_d;
    logic [3:0]     st_wstrb_q, st_wstrb_d;
    logic [31:0]    st_data_q, st_data_d;

    // Capture the pending store together with the miss it belongs to
    always_comb begin
        st_valid_d = st_valid_q;
        st_word_d  = st_word_q;
        st_wstrb_d = st_wstrb_q;
        st_data_d  = st_data_q;
        if (w_accept) begin
            st_valid_d = bus.st_valid;
            st_word_d  = bus.st_word;
            st_wstrb_d = bus.st_wstrb;
            st_data_d  = bus.st_data;
        end
    end

    // Store capture registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            st_valid_q <= 1'b0;
            st_word_q  <= '0;
            st_wstrb_q <= '0;
            st_data_q  <= '0;
        end else begin
            st_valid_q <= st_valid_d;
            st_word_q  <= st_word_d;
            st_wstrb_q <= st_wstrb_d;
            st_data_q  <= st_data_d;
        end
    end

    // Store bytes win over refill bytes in the targeted word
    always_comb begin
        w_line_merged = line_q;
        for (int b = 0; b < 4; b++) begin
            if (st_valid_q && st_wstrb_q[b]) begin
                w_line_merged[{st_word_q, 5'b0} + 8'(8 * b) +: 8] = st_data_q[8*b +: 8];
            end
        end
    end

    assign w_unused = ^bus.req_addr[4:0];
`else
    // Line goes to the RAM exactly as refilled; the store inputs are not used
    assign w_line_merged = line_q;
    assign w_unused      = ^{bus.req_addr[4:0], bus.st_valid, bus.st_word,
                             bus.st_wstrb, bus.st_data};
`endif

endmodule
`default_nettype wire

// File: doc/dcache_refill_buffer.md
DCACHE_REFILL_BUFFER -- requirements
Module: dcache_refill_buffer

Interface
REQ-001 SHALL have parameter LINE_WORDS, default 8, meaning 32-bit beats per 256-bit line; only value 8 is supported.
REQ-002 SHALL have parameter INDEX_W, default 7, meaning set-index width, taken from addr[11:5].
REQ-003 SHALL have port clk, input, 1, meaning the single clock; all logic on its rising edge.
REQ-004 SHALL have port resetn, input, 1, meaning reset, asynchronous and active-low.
REQ-005 SHALL have ports req_valid/req_ready, in/out, 1/1, meaning the miss-request handshake.
REQ-006 SHALL have port req_addr, input, 32, meaning the miss address; bits [4:0] are ignored.
REQ-007 SHALL have ports st_valid, st_word, st_wstrb, st_data, input, 1/3/4/32, meaning the pending store captured with req.
REQ-008 SHALL have ports arvalid/arready, out/in, 1/1, and araddr/arlen/arsize/arburst, out, 32/8/3/2, meaning the AXI read address channel.
REQ-009 SHALL have ports rvalid/rready, in/out, 1/1, and rdata/rlast, in, 32/1, meaning the AXI read data channel.
REQ-010 SHALL have ports ram_wen, ram_windex, ram_wdata, out, 32/7/256, meaning the byte-enabled line write into the data RAM.
REQ-011 SHALL have ports done and err, out, 1/1, meaning the refill-complete pulse and the burst-framing error.

Function
REQ-012 SHALL implement FSM IDLE -> ADDR -> RECV -> WRITE -> IDLE.
REQ-013 SHALL assert req_ready only in IDLE; req_valid&&req_ready latches addr, index and store fields and moves to ADDR.
REQ-014 In ADDR SHALL hold arvalid=1, araddr={addr[31:5],5'b0}, arlen=7, arsize=2, arburst=2'b01; arready moves to RECV.
REQ-015 SHALL drive arlen/arsize/arburst constant; araddr is valid only while arvalid=1.
REQ-016 In RECV SHALL assert rready=1; each rvalid beat k (k=0..7, 3-bit counter) stores rdata into line bits [32k+31:32k].
REQ-017 After the 8th beat SHALL enter WRITE; the ADDR->RECV->WRITE path has no bubbles beyond AXI stalls.
REQ-018 In WRITE, for exactly one cycle, SHALL drive ram_wen=32'hFFFFFFFF, ram_windex=latched index, ram_wdata=assembled line, done=1; next state is IDLE.
REQ-019 Outside WRITE, ram_wen SHALL be 0; done SHALL be a one-cycle pulse.
REQ-020 err SHALL pulse with done if rlast was 1 on beat k<7 or 0 on beat 7; the line is still written.
REQ-021 Beats with rvalid=0 SHALL NOT advance the counter; rvalid outside RECV SHALL be ignored (rready=0).
REQ-022 A new req SHALL be accepted no earlier than the cycle after WRITE (req_ready=1 in IDLE).
REQ-023 Minimum latency with arready and rvalid always high SHALL be 11 cycles, from the req handshake to the done pulse.

Reset
REQ-024 resetn=0 SHALL immediately force IDLE, counter=0, and arvalid, rready, ram_wen, done and err to 0, req_ready to 1.
REQ-025 Reset mid-burst SHALL abandon the refill with no RAM write; the line buffer content is don't-care.

Configuration
REQ-026 With REFILL_STORE_MERGE_EN defined, in WRITE bytes of word st_word whose st_wstrb bit is set SHALL take st_data instead of refill data, when latched st_valid=1.
REQ-027 Without REFILL_STORE_MERGE_EN, st_* inputs SHALL be ignored and the line SHALL be exactly the refill data.

Verification
REQ-028 Reset, then req addr=0x0000_1A64, arready=rvalid=1, beats 0x11111111*(k+1), rlast on beat 7 -> araddr=0x0000_1A60, arlen=7; ram_windex=0x53, ram_wen=all-ones, word k=0x11111111*(k+1); done at cycle 11; err=0.
REQ-029 Same request with rvalid low for 2 cycles after beat 3 and arready delayed 3 cycles -> done at cycle 16 with identical line.
REQ-030 With the macro defined, st_valid=1, st_word=2, st_wstrb=4'b0101, st_data=0xAABBCCDD over the REQ-028 beats -> word 2=0x33BB33DD; without the macro, word 2=0x33333333.
REQ-031 rlast=1 on beat 5 -> all 8 beats still collected, line written, err=1 with done.
REQ-032 resetn low during beat 4 -> ram_wen stays 0, FSM in IDLE and req_ready=1 after release; the next refill completes normally.
REQ-033 A second req_valid held during a refill -> accepted only in the cycle after done; two sequential lines are written correctly.
